// File: rtl/cla_share_ctrl.sv
// rtl/cla_share_ctrl.sv - round-robin sequencer sharing one carry-lookahead adder among requesters
module cla_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDW     = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_sub,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]         cla_a,
    output logic [WIDTH-1:0]         cla_b,
    output logic                     cla_c0,
    input  logic [WIDTH-1:0]         cla_s,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [IDW-1:0]           resp_id,
    output logic [WIDTH-1:0]         resp_sum,
    output logic                     resp_ovf,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IDW-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [IDW-1:0]   id_q,       id_d;
    logic [WIDTH-1:0] op_a_q,     op_a_d;
    logic [WIDTH-1:0] op_b_q,     op_b_d;
    logic             op_c0_q,    op_c0_d;
    logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
    logic             resp_ovf_q, resp_ovf_d;
    logic [IDW-1:0]   resp_id_q,  resp_id_d;

    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [IDW:0]     cand;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[IDW-1:0];
            end
        end
    end

    // Operand mux for the current winner
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == IDW'(i)) begin
                win_a = req_a[i*WIDTH +: WIDTH];
                win_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, one settle cycle in EXEC, hold in RESP until consumed
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: grant only in IDLE, and never while reset is held
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && win_found && reset_n) begin
            req_ready[win_id] = 1'b1;
        end
        resp_valid = (state_q == RESP);
        busy       = (state_q != IDLE);
    end

    // Datapath next-state: latch operands on accept, capture the adder result after EXEC
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        id_d       = id_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_c0_d    = op_c0_q;
        resp_sum_d = resp_sum_q;
        resp_ovf_d = resp_ovf_q;
        resp_id_d  = resp_id_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    op_a_d  = win_a;
                    op_b_d  = req_sub[win_id] ? ~win_b : win_b;
                    op_c0_d = req_sub[win_id];
                    id_d    = win_id;
                end
            end
            EXEC: begin
                resp_sum_d = cla_s;
                resp_ovf_d = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                             (cla_s[WIDTH-1] != op_a_q[WIDTH-1]);
                resp_id_d  = id_q;
            end
            RESP: begin
                if (resp_ready) begin
                    rr_ptr_d = (id_q == IDW'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= '0;
            id_q       <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_c0_q    <= 1'b0;
            resp_sum_q <= '0;
            resp_ovf_q <= 1'b0;
            resp_id_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_c0_q    <= op_c0_d;
            resp_sum_q <= resp_sum_d;
            resp_ovf_q <= resp_ovf_d;
            resp_id_q  <= resp_id_d;
        end
    end

    // Adder inputs come straight from registers so they stay quiet outside EXEC
    assign cla_a    = op_a_q;
    assign cla_b    = op_b_q;
    assign cla_c0   = op_c0_q;
    assign resp_sum = resp_sum_q;
    assign resp_ovf = resp_ovf_q;
    assign resp_id  = resp_id_q;

endmodule

// File: tb/tb_cla_share_ctrl.sv
// tb/tb_cla_share_ctrl.sv - self-checking bench for cla_share_ctrl
module tb_cla_share_ctrl;

    localparam int N = 4;
    localparam int W = 32;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_sub = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [W-1:0]   cla_a, cla_b, cla_s;
    logic           cla_c0;
    logic           resp_valid;
    logic           resp_ready = 1'b1;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_sum;
    logic           resp_ovf;
    logic           busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    cla_share_ctrl #(.NUM_REQ(N), .WIDTH(W), .IDW(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
        .req_a(req_a), .req_b(req_b),
        .cla_a(cla_a), .cla_b(cla_b), .cla_c0(cla_c0), .cla_s(cla_s),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_sum(resp_sum), .resp_ovf(resp_ovf), .busy(busy)
    );

    // The shared adder itself
    assign cla_s = cla_a + cla_b + {31'd0, cla_c0};

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]      = 1'b1;
        req_sub[i]        = sub;
        req_a[i*W +: W]   = a;
        req_b[i*W +: W]   = b;
    endtask

    // ---------------- behavioural model + compare ----------------
    bit          m_pend = 0;
    int          m_age = 0;
    int          m_ptr = 0;
    int          m_id = 0;
    logic [W-1:0] m_sum = '0;
    logic        m_ovf = 0;
    logic [W-1:0] m_la = '0, m_lb = '0;
    logic        m_lc = 0;

    always @(negedge clock) begin
        int w;
        logic [N-1:0] exp_rdy;
        longint sa, sb, r;
        if (!reset_n) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_resp_sum", resp_sum, 0);
            check("rst_resp_id", resp_id, 0);
            check("rst_resp_ovf", resp_ovf, 0);
            check("rst_cla_a", cla_a, 0);
            check("rst_cla_b", cla_b, 0);
            check("rst_cla_c0", cla_c0, 0);
            m_pend = 0; m_ptr = 0; m_la = '0; m_lb = '0; m_lc = 0;
        end else begin
            check("m_cla_a", cla_a, m_la);
            check("m_cla_b", cla_b, m_lb);
            check("m_cla_c0", cla_c0, m_lc);
            if (!m_pend) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                exp_rdy = '0;
                if (w >= 0) exp_rdy[w] = 1'b1;
                check("m_req_ready", req_ready, exp_rdy);
                check("m_resp_valid_idle", resp_valid, 0);
                check("m_busy_idle", busy, 0);
                if (w >= 0) begin
                    sa = longint'($signed(req_a[w*W +: W]));
                    sb = longint'($signed(req_b[w*W +: W]));
                    r  = req_sub[w] ? sa - sb : sa + sb;
                    m_sum = r[W-1:0];
                    m_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                    m_id  = w;
                    m_la  = req_a[w*W +: W];
                    m_lb  = req_sub[w] ? ~req_b[w*W +: W] : req_b[w*W +: W];
                    m_lc  = req_sub[w];
                    m_pend = 1; m_age = 1;
                end
            end else begin
                check("m_req_ready_busy", req_ready, 0);
                check("m_busy", busy, 1);
                if (m_age == 1) begin
                    check("m_resp_valid_exec", resp_valid, 0);
                    m_age = 2;
                end else begin
                    check("m_resp_valid", resp_valid, 1);
                    check("m_resp_id", resp_id, m_id);
                    check("m_resp_sum", resp_sum, m_sum);
                    check("m_resp_ovf", resp_ovf, m_ovf);
                    if (resp_ready) begin
                        m_pend = 0;
                        m_ptr = (m_id + 1) % N;
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic single_job(input int i, input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] exp_clab, input logic [W-1:0] exp_sum, input logic exp_ovf);
        @(posedge clock); #1;
        set_req(i, sub, a, b);
        resp_ready = 1'b1;
        @(negedge clock);
        check("job_grant", req_ready, 4'b0001 << i);
        @(posedge clock); #1;
        req_valid[i] = 1'b0;
        @(negedge clock);
        check("job_cla_b", cla_b, exp_clab);
        check("job_cla_c0", cla_c0, sub);
        check("job_exec_valid", resp_valid, 0);
        @(negedge clock);
        check("job_resp_valid", resp_valid, 1);
        check("job_resp_id", resp_id, i);
        check("job_resp_sum", resp_sum, exp_sum);
        check("job_resp_ovf", resp_ovf, exp_ovf);
        @(negedge clock);
        check("job_idle_after", resp_valid, 0);
    endtask

    int order[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        int n, prev;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // basic add, subtract, overflow corners
        single_job(0, 1'b0, 32'd1, 32'd0, 32'd0, 32'd1, 1'b0);
        single_job(2, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 1'b0);
        single_job(1, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd1, 32'h8000_0000, 1'b1);
        single_job(1, 1'b1, 32'h8000_0000, 32'd1, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 1'b1);
        single_job(3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b0);

        // all requesters valid: round-robin order and 3-cycle spacing
        @(posedge clock); #1;
        for (int i = 0; i < N; i++) set_req(i, i[0], 32'd100 * (i + 1), i + 1);
        prev = 0;
        for (int j = 0; j < 6; j++) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (req_ready == 0 && n < 10);
            if (req_ready == 0) begin
                check("rr_grant_timeout", 1, 0);
            end else begin
                check("rr_grant_order", req_ready, 4'b0001 << order[j]);
                if (j > 0) check("rr_spacing", cyc - prev, 3);
                prev = cyc;
            end
            @(posedge clock); #1;
            if (j == 5) req_valid = '0;
        end
        repeat (4) @(posedge clock);
        #1;

        // back-pressure on the response
        set_req(0, 1'b0, 32'd10, 32'd20);
        set_req(1, 1'b0, 32'd3, 32'd4);
        resp_ready = 1'b0;
        @(negedge clock);
        check("bp_grant", req_ready, 4'b0001);
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        @(negedge clock);
        check("bp_exec_busy", busy, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("bp_hold_valid", resp_valid, 1);
            check("bp_hold_sum", resp_sum, 32'd30);
            check("bp_hold_id", resp_id, 0);
            check("bp_hold_ready", req_ready, 0);
        end
        @(posedge clock); #1;
        resp_ready = 1'b1;
        @(negedge clock);
        check("bp_no_early_grant", req_ready, 0);
        @(negedge clock);
        check("bp_next_grant", req_ready, 4'b0010);
        check("bp_idle_valid", resp_valid, 0);
        @(posedge clock); #1;
        req_valid[1] = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // asynchronous reset in the middle of EXEC
        set_req(0, 1'b0, 32'd1, 32'd1);
        set_req(3, 1'b0, 32'd7, 32'd2);
        @(negedge clock);
        check("ar_grant", req_ready, 4'b1000);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_req_ready", req_ready, 0);
        check("ar_resp_valid", resp_valid, 0);
        check("ar_cla_a", cla_a, 0);
        check("ar_cla_c0", cla_c0, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("ar_first_grant", req_ready, 4'b0001);
        check("ar_no_stale_valid", resp_valid, 0);
        @(posedge clock); #1;
        req_valid = '0;
        repeat (4) @(posedge clock);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
